// File: rtl/spi_target.sv
// SPI mode-0 target: one byte per transfer, MSB first, with a strobe/ready CPU handshake.
// All SPI pins are oversampled in raw_clk through synchronizers and registered edge pulses.
module spi_target #(
  parameter logic [7:0] FILL_BYTE   = 8'hff,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic       spi_cs,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_strobe,
  output logic       tx_pending,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ready_clear,
  output logic       overrun,
  output logic       selected,
  output logic [7:0] byte_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] cs_pipe, sclk_pipe, mosi_pipe;
  logic cs_sync, sclk_sync, mosi_sync;
  logic cs_prev, sclk_prev;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  logic [7:0] tx_hold, tx_shift, reload_byte;
  logic [6:0] rx_shift;
  logic [2:0] bit_count;
  logic       start, stop, bit_rise, bit_fall, reload, complete;

  assign cs_sync   = cs_pipe[SYNC_STAGES-1];
  assign sclk_sync = sclk_pipe[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

  // CS synchronizer resets low so a CS already held low at reset release produces no falling edge
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      cs_pipe   <= '0;
      sclk_pipe <= '0;
      mosi_pipe <= '0;
      cs_prev   <= 1'b0;
      sclk_prev <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], spi_cs};
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], spi_clk};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
      cs_prev   <= cs_sync;
      sclk_prev <= sclk_sync;
      cs_fall   <= cs_prev & ~cs_sync;
      cs_rise   <= ~cs_prev & cs_sync;
      sclk_rise <= ~sclk_prev & sclk_sync;
      sclk_fall <= sclk_prev & ~sclk_sync;
    end
  end

  always_ff @(posedge raw_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    bit_rise   = 1'b0;
    bit_fall   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = ACTIVE;
          start      = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next = IDLE;
          stop       = 1'b1;
        end else begin
          bit_rise = sclk_rise;
          bit_fall = sclk_fall;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign reload      = start | (bit_fall & (bit_count == 3'd0));
  assign complete    = bit_rise & (bit_count == 3'd7);
  assign reload_byte = tx_pending ? tx_hold : FILL_BYTE;

  assign selected    = (state == ACTIVE);
  assign spi_miso_oe = selected;
  assign spi_miso    = selected & tx_shift[7];

  // A byte completion takes priority over a coincident rx_ready_clear
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      tx_hold    <= 8'h00;
      tx_pending <= 1'b0;
      tx_shift   <= 8'h00;
      rx_shift   <= 7'h00;
      rx_data    <= 8'h00;
      rx_ready   <= 1'b0;
      overrun    <= 1'b0;
      bit_count  <= 3'd0;
      byte_count <= 8'h00;
    end else begin
      if (tx_strobe) begin
        tx_hold    <= tx_data;
        tx_pending <= 1'b1;
      end else if (reload) begin
        tx_pending <= 1'b0;
      end

      if (rx_ready_clear && !complete) begin
        rx_ready <= 1'b0;
        overrun  <= 1'b0;
      end

      if (start) begin
        bit_count  <= 3'd0;
        byte_count <= 8'h00;
        tx_shift   <= reload_byte;
      end

      if (stop) bit_count <= 3'd0;

      if (bit_rise) begin
        rx_shift  <= {rx_shift[5:0], mosi_sync};
        bit_count <= bit_count + 3'd1;
        if (complete) begin
          rx_data  <= {rx_shift, mosi_sync};
          rx_ready <= 1'b1;
          if (rx_ready && !rx_ready_clear) overrun <= 1'b1;
          if (byte_count != 8'hff) byte_count <= byte_count + 8'd1;
        end
      end

      if (bit_fall) begin
        if (bit_count == 3'd0) tx_shift <= reload_byte;
        else                   tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: vector table, hand-written corner cases and
// randomized transactions checked against a byte-level behavioural model.
module tb_spi_target;

  localparam int         HALF = 6;
  localparam logic [7:0] FILL = 8'hff;

  logic       raw_clk = 1'b0;
  logic       reset, spi_cs, spi_clk, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_strobe, tx_pending;
  logic [7:0] rx_data;
  logic       rx_ready, rx_ready_clear, overrun, selected;
  logic [7:0] byte_count;

  int checks = 0;
  int errors = 0;

  // byte-level reference model
  bit         m_pending, m_ready, m_ovr;
  logic [7:0] m_hold, m_rx, m_count, m_cur;

  typedef struct {
    bit         do_clear;
    bit         do_strobe;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    bit         exp_ready;
    bit         exp_ovr;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[5];

  spi_target dut (
    .raw_clk        (raw_clk),
    .reset          (reset),
    .spi_cs         (spi_cs),
    .spi_clk        (spi_clk),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .spi_miso_oe    (spi_miso_oe),
    .tx_data        (tx_data),
    .tx_strobe      (tx_strobe),
    .tx_pending     (tx_pending),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .rx_ready_clear (rx_ready_clear),
    .overrun        (overrun),
    .selected       (selected),
    .byte_count     (byte_count)
  );

  always #5 raw_clk = ~raw_clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge raw_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%02h expected=%02h", name, actual, expected);
    end
  endtask

  task automatic do_strobe(input logic [7:0] d);
    tx_data   = d;
    tx_strobe = 1'b1;
    wait_cycles(1);
    tx_strobe = 1'b0;
  endtask

  task automatic do_clear();
    rx_ready_clear = 1'b1;
    wait_cycles(1);
    rx_ready_clear = 1'b0;
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_cycles(HALF);
  endtask

  task automatic cs_high();
    spi_cs = 1'b1;
    wait_cycles(HALF);
  endtask

  // Master side of one byte (or nbits of it); optional pulses land on the DUT's action cycle
  task automatic spi_xfer(input logic [7:0] mosi_byte, input int nbits, input bit clear_at_done,
                          input bit strobe_at_reload, input logic [7:0] strobe_byte,
                          output logic [7:0] miso_byte);
    miso_byte = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mosi_byte[i];
      wait_cycles(HALF);
      miso_byte[i] = spi_miso;
      spi_clk = 1'b1;
      if (i == 0 && clear_at_done) begin
        wait_cycles(3);
        rx_ready_clear = 1'b1;
        wait_cycles(1);
        rx_ready_clear = 1'b0;
        wait_cycles(HALF - 4);
      end else begin
        wait_cycles(HALF);
      end
      spi_clk = 1'b0;
      if (i == 0 && strobe_at_reload) begin
        wait_cycles(3);
        tx_data   = strobe_byte;
        tx_strobe = 1'b1;
        wait_cycles(1);
        tx_strobe = 1'b0;
        wait_cycles(HALF - 4);
      end else begin
        wait_cycles(HALF);
      end
    end
  endtask

  task automatic spi_byte(input logic [7:0] mosi_byte, output logic [7:0] miso_byte);
    spi_xfer(mosi_byte, 8, 1'b0, 1'b0, 8'h00, miso_byte);
  endtask

  task automatic applyStimulus(input vec_t v, output logic [7:0] miso_byte);
    if (v.do_clear) do_clear();
    if (v.do_strobe) do_strobe(v.tx);
    cs_low();
    spi_byte(v.mosi, miso_byte);
    cs_high();
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, " spi_miso"}, {7'b0, spi_miso}, 8'h00);
    checkOutput({tag, " spi_miso_oe"}, {7'b0, spi_miso_oe}, 8'h00);
    checkOutput({tag, " tx_pending"}, {7'b0, tx_pending}, 8'h00);
    checkOutput({tag, " rx_data"}, rx_data, 8'h00);
    checkOutput({tag, " rx_ready"}, {7'b0, rx_ready}, 8'h00);
    checkOutput({tag, " overrun"}, {7'b0, overrun}, 8'h00);
    checkOutput({tag, " selected"}, {7'b0, selected}, 8'h00);
    checkOutput({tag, " byte_count"}, byte_count, 8'h00);
  endtask

  function automatic logic [7:0] model_next_byte();
    logic [7:0] b;
    b = m_pending ? m_hold : FILL;
    m_pending = 1'b0;
    return b;
  endfunction

  function automatic void model_byte_done(input logic [7:0] mosi_byte);
    if (m_ready) m_ovr = 1'b1;
    m_ready = 1'b1;
    m_rx    = mosi_byte;
    if (m_count != 8'd255) m_count = m_count + 8'd1;
    m_cur = model_next_byte();
  endfunction

  task automatic check_model(input string tag);
    checkOutput({tag, " rx_data"}, rx_data, m_rx);
    checkOutput({tag, " rx_ready"}, {7'b0, rx_ready}, {7'b0, m_ready});
    checkOutput({tag, " overrun"}, {7'b0, overrun}, {7'b0, m_ovr});
    checkOutput({tag, " byte_count"}, byte_count, m_count);
    checkOutput({tag, " tx_pending"}, {7'b0, tx_pending}, {7'b0, m_pending});
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] mb;
    int         nb;

    vecs[0] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'd1};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 8'h55, 8'hFF, 8'h55, 1'b1, 1'b1, 8'd1};
    vecs[2] = '{1'b1, 1'b1, 8'h7E, 8'h00, 8'h7E, 8'h00, 1'b1, 1'b0, 8'd1};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'd1};
    vecs[4] = '{1'b0, 1'b1, 8'h80, 8'h81, 8'h80, 8'h81, 1'b1, 1'b1, 8'd1};

    reset = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    tx_data = 8'h00; tx_strobe = 1'b0; rx_ready_clear = 1'b0;
    wait_cycles(3);
    check_reset_values("reset");
    reset = 1'b0;
    wait_cycles(HALF);

    // single-byte transactions from the vector table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], got);
      checkOutput($sformatf("vec%0d miso", i), got, vecs[i].exp_miso);
      checkOutput($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_rx);
      checkOutput($sformatf("vec%0d rx_ready", i), {7'b0, rx_ready}, {7'b0, vecs[i].exp_ready});
      checkOutput($sformatf("vec%0d overrun", i), {7'b0, overrun}, {7'b0, vecs[i].exp_ovr});
      checkOutput($sformatf("vec%0d byte_count", i), byte_count, vecs[i].exp_count);
      checkOutput($sformatf("vec%0d tx_pending", i), {7'b0, tx_pending}, 8'h00);
      checkOutput($sformatf("vec%0d miso_oe", i), {7'b0, spi_miso_oe}, 8'h00);
    end

    // two bytes with a clear between them
    do_clear();
    cs_low();
    spi_byte(8'h01, got);
    checkOutput("two miso0", got, 8'hFF);
    checkOutput("two ready0", {7'b0, rx_ready}, 8'h01);
    do_clear();
    spi_byte(8'h02, got);
    checkOutput("two miso1", got, 8'hFF);
    cs_high();
    checkOutput("two rx_data", rx_data, 8'h02);
    checkOutput("two overrun", {7'b0, overrun}, 8'h00);
    checkOutput("two byte_count", byte_count, 8'd2);

    // three bytes without clearing
    do_clear();
    cs_low();
    spi_byte(8'h11, got);
    checkOutput("three ovr after 1", {7'b0, overrun}, 8'h00);
    spi_byte(8'h22, got);
    checkOutput("three ovr after 2", {7'b0, overrun}, 8'h01);
    spi_byte(8'h33, got);
    cs_high();
    checkOutput("three rx_data", rx_data, 8'h33);
    checkOutput("three byte_count", byte_count, 8'd3);
    do_clear();
    checkOutput("three cleared ready", {7'b0, rx_ready}, 8'h00);
    checkOutput("three cleared ovr", {7'b0, overrun}, 8'h00);

    // clear coinciding with byte completion: completion wins
    cs_low();
    spi_byte(8'h44, got);
    spi_xfer(8'h99, 8, 1'b1, 1'b0, 8'h00, got);
    cs_high();
    checkOutput("coinc rx_ready", {7'b0, rx_ready}, 8'h01);
    checkOutput("coinc overrun", {7'b0, overrun}, 8'h00);
    checkOutput("coinc rx_data", rx_data, 8'h99);

    // partial byte discarded
    do_clear();
    cs_low();
    spi_xfer(8'hA8, 5, 1'b0, 1'b0, 8'h00, got);
    cs_high();
    checkOutput("partial rx_ready", {7'b0, rx_ready}, 8'h00);
    checkOutput("partial miso_oe", {7'b0, spi_miso_oe}, 8'h00);
    checkOutput("partial byte_count", byte_count, 8'd0);
    cs_low();
    spi_byte(8'h81, got);
    cs_high();
    checkOutput("after partial rx_data", rx_data, 8'h81);
    checkOutput("after partial rx_ready", {7'b0, rx_ready}, 8'h01);
    checkOutput("after partial byte_count", byte_count, 8'd1);

    // tx_strobe on the exact reload cycle
    do_clear();
    cs_low();
    do_strobe(8'h22);
    spi_xfer(8'h00, 8, 1'b0, 1'b1, 8'h11, got);
    checkOutput("reload miso0", got, 8'hFF);
    checkOutput("reload pending", {7'b0, tx_pending}, 8'h01);
    spi_byte(8'h00, got);
    checkOutput("reload miso1", got, 8'h22);
    spi_byte(8'h00, got);
    checkOutput("reload miso2", got, 8'h11);
    cs_high();
    checkOutput("reload pending end", {7'b0, tx_pending}, 8'h00);

    // reset mid-byte with CS held low
    do_strobe(8'h33);
    cs_low();
    spi_xfer(8'hF0, 4, 1'b0, 1'b0, 8'h00, got);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(1);
    check_reset_values("midreset");
    spi_byte(8'h5A, got);
    checkOutput("midreset ignored sel", {7'b0, selected}, 8'h00);
    checkOutput("midreset ignored ready", {7'b0, rx_ready}, 8'h00);
    checkOutput("midreset ignored count", byte_count, 8'h00);
    cs_high();
    cs_low();
    spi_byte(8'h5A, got);
    cs_high();
    checkOutput("midreset miso", got, 8'hFF);
    checkOutput("midreset rx_data", rx_data, 8'h5A);
    checkOutput("midreset byte_count", byte_count, 8'd1);

    // byte_count saturation
    cs_low();
    for (int i = 0; i < 256; i++) begin
      spi_byte(8'($urandom), got);
      if (i == 254) checkOutput("sat count 255", byte_count, 8'd255);
    end
    cs_high();
    checkOutput("sat count 256", byte_count, 8'd255);

    // randomized transactions against the model
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(HALF);
    m_pending = 1'b0; m_ready = 1'b0; m_ovr = 1'b0;
    m_hold = 8'h00; m_rx = 8'h00; m_count = 8'h00; m_cur = FILL;
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        mb = 8'($urandom);
        do_strobe(mb);
        m_pending = 1'b1;
        m_hold    = mb;
      end
      if ($urandom_range(0, 2) == 0) begin
        do_clear();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
      end
      cs_low();
      m_count = 8'h00;
      m_cur   = model_next_byte();
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        mb = 8'($urandom);
        spi_byte(mb, got);
        checkOutput($sformatf("rnd t%0d b%0d miso", t, b), got, m_cur);
        model_byte_done(mb);
        check_model($sformatf("rnd t%0d b%0d", t, b));
        if ($urandom_range(0, 2) == 0) begin
          mb = 8'($urandom);
          do_strobe(mb);
          m_pending = 1'b1;
          m_hold    = mb;
        end
        if ($urandom_range(0, 2) == 0) begin
          do_clear();
          m_ready = 1'b0;
          m_ovr   = 1'b0;
        end
      end
      cs_high();
      checkOutput($sformatf("rnd t%0d selected", t), {7'b0, selected}, 8'h00);
      check_model($sformatf("rnd t%0d end", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
